// File: rtl/ysyx_24080006_pkg.sv
// Shared types for the AXI arbiter: FSM states, master indices, request-vector layout.
// Build option YSYX_24080006_ARB_RR_EN (see ysyx_24080006_arb_pick) selects round-robin reads.
package ysyx_24080006_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        R_IFU = 2'd1,
        R_LSU = 2'd2,
        W_LSU = 2'd3
    } arb_state_e;

    typedef enum logic {
        MST_IFU = 1'b0,
        MST_LSU = 1'b1
    } arb_mst_e;

    localparam int REQ_IFU_R = 0;
    localparam int REQ_LSU_R = 1;
    localparam int REQ_LSU_W = 2;
    localparam int REQ_N     = 3;

    // Maps a one-hot grant to the forwarding state; no grant stays in IDLE.
    function automatic arb_state_e gnt_to_state(input logic [REQ_N-1:0] gnt);
        arb_state_e st;
        st = IDLE;
        if (gnt[REQ_LSU_W])      st = W_LSU;
        else if (gnt[REQ_LSU_R]) st = R_LSU;
        else if (gnt[REQ_IFU_R]) st = R_IFU;
        return st;
    endfunction

endpackage

// File: rtl/ysyx_24080006_axi.sv
// AXI4 bundle shared by IFU, LSU and the downstream crossbar port.
// master modport drives requests; slave modport drives responses.
interface ysyx_24080006_axi;
    import ysyx_24080006_pkg::*;

    logic                  arvalid;
    logic                  arready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [AXI_ID_W-1:0]   arid;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid;
    logic                  rready;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [AXI_ID_W-1:0]   rid;

    logic                  awvalid;
    logic                  awready;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [AXI_ID_W-1:0]   awid;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid;
    logic                  wready;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic [AXI_ID_W-1:0]   bid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );

endinterface

// File: rtl/ysyx_24080006_arb_pick.sv
// Combinational grant selection. With YSYX_24080006_ARB_RR_EN defined, contending reads
// alternate via last_grant; otherwise fixed priority lsu_w > lsu_r > ifu_r.
module ysyx_24080006_arb_pick
    import ysyx_24080006_pkg::*;
(
    input  logic [REQ_N-1:0] req,
    input  arb_mst_e         last_grant,
    output logic [REQ_N-1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req[REQ_LSU_W]) begin
            gnt[REQ_LSU_W] = 1'b1;
        end
`ifdef YSYX_24080006_ARB_RR_EN
        else if (req[REQ_LSU_R] && req[REQ_IFU_R]) begin
            if (last_grant == MST_LSU) gnt[REQ_IFU_R] = 1'b1;
            else                       gnt[REQ_LSU_R] = 1'b1;
        end
`endif
        else if (req[REQ_LSU_R]) begin
            gnt[REQ_LSU_R] = 1'b1;
        end
        else if (req[REQ_IFU_R]) begin
            gnt[REQ_IFU_R] = 1'b1;
        end
    end

`ifndef YSYX_24080006_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/ysyx_24080006_axi_arbiter.sv
// Two-master AXI arbiter (IFU read-only, LSU read/write) onto one downstream port.
// Build option YSYX_24080006_ARB_RR_EN enables round-robin read arbitration.
module ysyx_24080006_axi_arbiter
    import ysyx_24080006_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    ysyx_24080006_axi.slave  axi_ifu,
    ysyx_24080006_axi.slave  axi_lsu,
    ysyx_24080006_axi.master axi_out
);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic [REQ_N-1:0] req;
    logic [REQ_N-1:0] gnt;
    arb_mst_e         last_grant;
    logic             rd_done;
    logic             wr_done;

    // Requests are only acted on in IDLE; IFU write channels are never looked at.
    assign req = {axi_lsu.awvalid, axi_lsu.arvalid, axi_ifu.arvalid};

`ifdef YSYX_24080006_ARB_RR_EN
    arb_mst_e last_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= MST_LSU;
        end else if (state_q == IDLE && (gnt[REQ_IFU_R] || gnt[REQ_LSU_R])) begin
            last_q <= gnt[REQ_LSU_R] ? MST_LSU : MST_IFU;
        end
    end

    assign last_grant = last_q;
`else
    assign last_grant = MST_LSU;
`endif

    ysyx_24080006_arb_pick u_pick (
        .req        (req),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    assign rd_done = axi_out.rvalid && axi_out.rready && axi_out.rlast;
    assign wr_done = axi_out.bvalid && axi_out.bready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         state_d = gnt_to_state(gnt);
            R_IFU, R_LSU: if (rd_done) state_d = IDLE;
            W_LSU:        if (wr_done) state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Forwarding is purely combinational; reset also masks it so nothing leaks mid-reset.
    always_comb begin
        axi_ifu.arready = 1'b0;
        axi_ifu.rvalid  = 1'b0;
        axi_ifu.rdata   = '0;
        axi_ifu.rresp   = '0;
        axi_ifu.rlast   = 1'b0;
        axi_ifu.rid     = '0;
        axi_ifu.awready = 1'b0;
        axi_ifu.wready  = 1'b0;
        axi_ifu.bvalid  = 1'b0;
        axi_ifu.bresp   = '0;
        axi_ifu.bid     = '0;

        axi_lsu.arready = 1'b0;
        axi_lsu.rvalid  = 1'b0;
        axi_lsu.rdata   = '0;
        axi_lsu.rresp   = '0;
        axi_lsu.rlast   = 1'b0;
        axi_lsu.rid     = '0;
        axi_lsu.awready = 1'b0;
        axi_lsu.wready  = 1'b0;
        axi_lsu.bvalid  = 1'b0;
        axi_lsu.bresp   = '0;
        axi_lsu.bid     = '0;

        axi_out.arvalid = 1'b0;
        axi_out.araddr  = '0;
        axi_out.arid    = '0;
        axi_out.arlen   = '0;
        axi_out.arsize  = '0;
        axi_out.arburst = '0;
        axi_out.rready  = 1'b0;
        axi_out.awvalid = 1'b0;
        axi_out.awaddr  = '0;
        axi_out.awid    = '0;
        axi_out.awlen   = '0;
        axi_out.awsize  = '0;
        axi_out.awburst = '0;
        axi_out.wvalid  = 1'b0;
        axi_out.wdata   = '0;
        axi_out.wstrb   = '0;
        axi_out.wlast   = 1'b0;
        axi_out.bready  = 1'b0;

        if (!reset) begin
            case (state_q)
                R_IFU: begin
                    axi_out.arvalid = axi_ifu.arvalid;
                    axi_out.araddr  = axi_ifu.araddr;
                    axi_out.arid    = axi_ifu.arid;
                    axi_out.arlen   = axi_ifu.arlen;
                    axi_out.arsize  = axi_ifu.arsize;
                    axi_out.arburst = axi_ifu.arburst;
                    axi_ifu.arready = axi_out.arready;
                    axi_ifu.rvalid  = axi_out.rvalid;
                    axi_ifu.rdata   = axi_out.rdata;
                    axi_ifu.rresp   = axi_out.rresp;
                    axi_ifu.rlast   = axi_out.rlast;
                    axi_ifu.rid     = axi_out.rid;
                    axi_out.rready  = axi_ifu.rready;
                end
                R_LSU: begin
                    axi_out.arvalid = axi_lsu.arvalid;
                    axi_out.araddr  = axi_lsu.araddr;
                    axi_out.arid    = axi_lsu.arid;
                    axi_out.arlen   = axi_lsu.arlen;
                    axi_out.arsize  = axi_lsu.arsize;
                    axi_out.arburst = axi_lsu.arburst;
                    axi_lsu.arready = axi_out.arready;
                    axi_lsu.rvalid  = axi_out.rvalid;
                    axi_lsu.rdata   = axi_out.rdata;
                    axi_lsu.rresp   = axi_out.rresp;
                    axi_lsu.rlast   = axi_out.rlast;
                    axi_lsu.rid     = axi_out.rid;
                    axi_out.rready  = axi_lsu.rready;
                end
                W_LSU: begin
                    axi_out.awvalid = axi_lsu.awvalid;
                    axi_out.awaddr  = axi_lsu.awaddr;
                    axi_out.awid    = axi_lsu.awid;
                    axi_out.awlen   = axi_lsu.awlen;
                    axi_out.awsize  = axi_lsu.awsize;
                    axi_out.awburst = axi_lsu.awburst;
                    axi_lsu.awready = axi_out.awready;
                    axi_out.wvalid  = axi_lsu.wvalid;
                    axi_out.wdata   = axi_lsu.wdata;
                    axi_out.wstrb   = axi_lsu.wstrb;
                    axi_out.wlast   = axi_lsu.wlast;
                    axi_lsu.wready  = axi_out.wready;
                    axi_lsu.bvalid  = axi_out.bvalid;
                    axi_lsu.bresp   = axi_out.bresp;
                    axi_lsu.bid     = axi_out.bid;
                    axi_out.bready  = axi_lsu.bready;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_axi_arbiter.sv
// Directed bench for ysyx_24080006_axi_arbiter with a queue scoreboard of expected grants and beats.
module tb_ysyx_24080006_axi_arbiter;

`ifdef YSYX_24080006_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ysyx_24080006_axi ifu_if ();
    ysyx_24080006_axi lsu_if ();
    ysyx_24080006_axi out_if ();

    ysyx_24080006_axi_arbiter dut (
        .clock   (clock),
        .reset   (reset),
        .axi_ifu (ifu_if),
        .axi_lsu (lsu_if),
        .axi_out (out_if)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_ar_q  [$];
    logic [7:0]  exp_len_q [$];
    bit          exp_mst_q [$];
    logic [31:0] exp_r_q   [$];
    logic [31:0] exp_aw_q  [$];
    logic [31:0] exp_w_q   [$];
    bit          tb_last = 1'b1;  // 1 = LSU, the post-reset value

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req_ar(input bit lsu, input logic [31:0] addr, input logic [7:0] len);
        if (lsu) begin
            lsu_if.arvalid = 1'b1; lsu_if.araddr = addr; lsu_if.arlen = len;
            lsu_if.arid = 4'h2; lsu_if.arsize = 3'd2; lsu_if.arburst = 2'b01;
        end else begin
            ifu_if.arvalid = 1'b1; ifu_if.araddr = addr; ifu_if.arlen = len;
            ifu_if.arid = 4'h1; ifu_if.arsize = 3'd2; ifu_if.arburst = 2'b01;
        end
    endtask

    task automatic expect_grant(input bit lsu, input logic [31:0] addr, input logic [7:0] len);
        exp_ar_q.push_back(addr);
        exp_len_q.push_back(len);
        exp_mst_q.push_back(lsu);
        tb_last = lsu;
    endtask

    task automatic wait_ar(output bit mst);
        int n;
        bit m;
        n = 0;
        m = 1'b0;
        @(negedge clock);
        while (out_if.arvalid !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (out_if.arvalid !== 1'b1 || exp_ar_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL ar_wait observed=no_arvalid_or_no_expectation expected=arvalid");
        end else begin
            m = exp_mst_q.pop_front();
            chk("ar_addr", out_if.araddr, exp_ar_q.pop_front());
            chk("ar_len", 32'(out_if.arlen), 32'(exp_len_q.pop_front()));
            chk("ar_id", 32'(out_if.arid), m ? 32'h2 : 32'h1);
            chk("ar_ready_granted", m ? 32'(lsu_if.arready) : 32'(ifu_if.arready), 32'd1);
            chk("ar_ready_other", m ? 32'(ifu_if.arready) : 32'(lsu_if.arready), 32'd0);
        end
        mst = m;
        tick();
        if (m) lsu_if.arvalid = 1'b0;
        else   ifu_if.arvalid = 1'b0;
    endtask

    task automatic r_beat(input bit lsu, input logic [31:0] data, input logic last);
        out_if.rvalid = 1'b1;
        out_if.rdata  = data;
        out_if.rlast  = last;
        out_if.rid    = lsu ? 4'h2 : 4'h1;
        exp_r_q.push_back(data);
        @(negedge clock);
        chk("r_valid_target", lsu ? 32'(lsu_if.rvalid) : 32'(ifu_if.rvalid), 32'd1);
        chk("r_data", lsu ? lsu_if.rdata : ifu_if.rdata, exp_r_q.pop_front());
        chk("r_last", lsu ? 32'(lsu_if.rlast) : 32'(ifu_if.rlast), 32'(last));
        chk("r_valid_other", lsu ? 32'(ifu_if.rvalid) : 32'(lsu_if.rvalid), 32'd0);
        chk("r_ar_other_blocked", lsu ? 32'(ifu_if.arready) : 32'(lsu_if.arready), 32'd0);
        chk("r_out_arvalid_quiet", 32'(out_if.arvalid), 32'd0);
        tick();
        out_if.rvalid = 1'b0;
        out_if.rlast  = 1'b0;
    endtask

    task automatic contend(input logic [31:0] ifu_addr, input logic [31:0] lsu_addr,
                           input logic [31:0] data);
        bit first;
        bit m;
        first = (RR && tb_last) ? 1'b0 : 1'b1;
        req_ar(1'b0, ifu_addr, 8'd0);
        req_ar(1'b1, lsu_addr, 8'd0);
        expect_grant(first, first ? lsu_addr : ifu_addr, 8'd0);
        expect_grant(!first, first ? ifu_addr : lsu_addr, 8'd0);
        @(negedge clock);
        chk("contend_latency", 32'(out_if.arvalid), 32'd0);
        wait_ar(m);
        r_beat(m, data, 1'b1);
        @(negedge clock);
        chk("contend_idle_gap", 32'(out_if.arvalid), 32'd0);
        wait_ar(m);
        r_beat(m, data + 32'd1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit m;
        int n;

        ifu_if.arvalid = 0; ifu_if.araddr = '0; ifu_if.arid = '0; ifu_if.arlen = '0;
        ifu_if.arsize = '0; ifu_if.arburst = '0; ifu_if.rready = 1'b1;
        ifu_if.awvalid = 0; ifu_if.awaddr = '0; ifu_if.awid = '0; ifu_if.awlen = '0;
        ifu_if.awsize = '0; ifu_if.awburst = '0; ifu_if.wvalid = 0; ifu_if.wdata = '0;
        ifu_if.wstrb = '0; ifu_if.wlast = 0; ifu_if.bready = 1'b1;
        lsu_if.arvalid = 0; lsu_if.araddr = '0; lsu_if.arid = '0; lsu_if.arlen = '0;
        lsu_if.arsize = '0; lsu_if.arburst = '0; lsu_if.rready = 1'b1;
        lsu_if.awvalid = 0; lsu_if.awaddr = '0; lsu_if.awid = '0; lsu_if.awlen = '0;
        lsu_if.awsize = '0; lsu_if.awburst = '0; lsu_if.wvalid = 0; lsu_if.wdata = '0;
        lsu_if.wstrb = '0; lsu_if.wlast = 0; lsu_if.bready = 1'b1;
        out_if.arready = 1'b1; out_if.rvalid = 0; out_if.rdata = '0; out_if.rresp = '0;
        out_if.rlast = 0; out_if.rid = '0; out_if.awready = 1'b1; out_if.wready = 1'b1;
        out_if.bvalid = 0; out_if.bresp = '0; out_if.bid = '0;

        // Reset held with live requests: every output must stay quiet.
        tick();
        ifu_if.arvalid = 1'b1; ifu_if.araddr = 32'h8000_0000;
        lsu_if.awvalid = 1'b1;
        out_if.rvalid = 1'b1; out_if.bvalid = 1'b1;
        tick(); tick();
        @(negedge clock);
        chk("rst_state", 32'(dut.state_q), 32'd0);
        chk("rst_out_arvalid", 32'(out_if.arvalid), 32'd0);
        chk("rst_out_awvalid", 32'(out_if.awvalid), 32'd0);
        chk("rst_ifu_rvalid", 32'(ifu_if.rvalid), 32'd0);
        chk("rst_lsu_bvalid", 32'(lsu_if.bvalid), 32'd0);
        chk("rst_lsu_awready", 32'(lsu_if.awready), 32'd0);
        tick();
        ifu_if.arvalid = 0; lsu_if.awvalid = 0; out_if.rvalid = 0; out_if.bvalid = 0;
        tick();
        reset = 1'b0;
        tick();

        // Lone IFU fetch.
        req_ar(1'b0, 32'hA000_0000, 8'd0);
        expect_grant(1'b0, 32'hA000_0000, 8'd0);
        @(negedge clock);
        chk("t1_latency", 32'(out_if.arvalid), 32'd0);
        wait_ar(m);
        r_beat(m, 32'h1234_5678, 1'b1);
        @(negedge clock);
        chk("t1_back_idle", 32'(dut.state_q), 32'd0);
        tick();

        // Simultaneous reads, then repeated contention.
        contend(32'h8000_0000, 32'h0F00_0010, 32'h0000_1000);
        tick();
        for (int i = 0; i < 4; i++) begin
            contend(32'h8000_0100 + 32'(i), 32'h0F00_0100 + 32'(i), 32'h0000_2000 + 32'(i * 16));
            tick();
        end

        // LSU write beats LSU read to the same CLINT address.
        lsu_if.awvalid = 1'b1; lsu_if.awaddr = 32'h0200_BFF8; lsu_if.awid = 4'h3;
        lsu_if.awlen = 8'd0; lsu_if.awsize = 3'd2; lsu_if.awburst = 2'b01;
        exp_aw_q.push_back(32'h0200_BFF8);
        req_ar(1'b1, 32'h0200_BFF8, 8'd0);
        expect_grant(1'b1, 32'h0200_BFF8, 8'd0);
        n = 0;
        @(negedge clock);
        while (out_if.awvalid !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("wr_aw_addr", out_if.awaddr, exp_aw_q.pop_front());
        chk("wr_aw_ready", 32'(lsu_if.awready), 32'd1);
        chk("wr_rd_blocked_aw", 32'(out_if.arvalid), 32'd0);
        tick();
        lsu_if.awvalid = 1'b0;
        lsu_if.wvalid = 1'b1; lsu_if.wdata = 32'hDEAD_BEEF; lsu_if.wstrb = 4'hF; lsu_if.wlast = 1'b1;
        exp_w_q.push_back(32'hDEAD_BEEF);
        @(negedge clock);
        chk("wr_w_data", out_if.wdata, exp_w_q.pop_front());
        chk("wr_w_strb", 32'(out_if.wstrb), 32'hF);
        chk("wr_w_ready", 32'(lsu_if.wready), 32'd1);
        tick();
        lsu_if.wvalid = 1'b0; lsu_if.wlast = 1'b0;
        out_if.bvalid = 1'b1; out_if.bresp = 2'b00; out_if.bid = 4'h3;
        @(negedge clock);
        chk("wr_b_valid", 32'(lsu_if.bvalid), 32'd1);
        chk("wr_b_id", 32'(lsu_if.bid), 32'h3);
        chk("wr_rd_blocked_b", 32'(out_if.arvalid), 32'd0);
        tick();
        out_if.bvalid = 1'b0;
        @(negedge clock);
        chk("wr_idle_gap", 32'(out_if.arvalid), 32'd0);
        wait_ar(m);
        r_beat(m, 32'h0000_CAFE, 1'b1);
        tick();

        // IFU 4-beat burst; LSU request raised at beat 2 must wait for rlast.
        req_ar(1'b0, 32'h8000_1000, 8'd3);
        expect_grant(1'b0, 32'h8000_1000, 8'd3);
        wait_ar(m);
        r_beat(m, 32'h1111_0000, 1'b0);
        req_ar(1'b1, 32'h0F00_0030, 8'd0);
        expect_grant(1'b1, 32'h0F00_0030, 8'd0);
        r_beat(m, 32'h1111_0001, 1'b0);
        r_beat(m, 32'h1111_0002, 1'b0);
        r_beat(m, 32'h1111_0003, 1'b1);
        @(negedge clock);
        chk("burst_idle_gap", 32'(out_if.arvalid), 32'd0);
        wait_ar(m);
        r_beat(m, 32'h2222_0000, 1'b1);
        tick();

        // Reset in R_LSU with a response pending; IFU write attempts stay invisible.
        ifu_if.awvalid = 1'b1; ifu_if.awaddr = 32'h1000_0000; ifu_if.wvalid = 1'b1;
        req_ar(1'b1, 32'h0F00_0040, 8'd0);
        expect_grant(1'b1, 32'h0F00_0040, 8'd0);
        wait_ar(m);
        out_if.rvalid = 1'b1; out_if.rdata = 32'h5555_AAAA; out_if.rlast = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_lsu_rvalid", 32'(lsu_if.rvalid), 32'd0);
        chk("mid_rst_out_rready", 32'(out_if.rready), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_state", 32'(dut.state_q), 32'd0);
        chk("mid_rst_lsu_rvalid_after", 32'(lsu_if.rvalid), 32'd0);
        chk("mid_rst_ifu_awready", 32'(ifu_if.awready), 32'd0);
        chk("mid_rst_ifu_wready", 32'(ifu_if.wready), 32'd0);
        chk("mid_rst_ifu_bvalid", 32'(ifu_if.bvalid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clock);
            chk("ifu_aw_ignored", 32'(out_if.awvalid), 32'd0);
            chk("ifu_w_ignored", 32'(out_if.wvalid), 32'd0);
            chk("ifu_aw_idle_ar", 32'(out_if.arvalid), 32'd0);
        end
        tick();
        out_if.rvalid = 1'b0; out_if.rlast = 1'b0;
        ifu_if.awvalid = 1'b0; ifu_if.wvalid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_24080006_axi_arbiter.md
YSYX_24080006_AXI_ARBITER -- requirements
Module: ysyx_24080006_axi_arbiter

Interface
REQ-001 SHALL have port `clock`  input  1  system clock; `reset` is synchronous, active-high; clock is `clock`.
REQ-002 SHALL have port `reset`  input  1  synchronous, active-high reset.
REQ-003 SHALL have port `axi_ifu`  slave modport  ysyx_24080006_axi  instruction-fetch master, read-only.
REQ-004 SHALL have port `axi_lsu`  slave modport  ysyx_24080006_axi  load/store master, read and write.
REQ-005 SHALL have port `axi_out`  master modport  ysyx_24080006_axi  shared downstream port (xbar → CLINT/SRAM/UART).

Function
REQ-006 SHALL use a registered FSM with states IDLE, R_IFU, R_LSU, W_LSU.
REQ-007 SHALL, in IDLE, sample requests: ifu_r=axi_ifu.arvalid, lsu_r=axi_lsu.arvalid, lsu_w=axi_lsu.awvalid.
- Grant decision is made in IDLE.
- Forwarding starts the following cycle (1-cycle arbitration latency).
REQ-008 SHALL, in fixed-priority mode, grant lsu_w over lsu_r over ifu_r.
REQ-009 SHALL, while granted, pass the granted master's AR/R or AW/W/B channels combinationally to axi_out, with all fields unchanged (addr, len, size, burst, data, strb, resp, last, id).
REQ-010 SHALL hold every non-granted master's ready/valid outputs (arready, awready, wready, rvalid, bvalid) at 0.
REQ-011 SHALL drive axi_out valids to 0 in IDLE.
REQ-012 SHALL release a read grant only on an axi_out R handshake with rlast=1; a beat with rlast=0 keeps the grant.
REQ-013 SHALL release a write grant only on an axi_out B handshake.
REQ-014 SHALL return to IDLE on release.
- No back-to-back grant in the release cycle.
- Minimum one IDLE cycle between transactions.
REQ-015 SHALL ignore axi_ifu.awvalid/wvalid.
- axi_ifu.awready, wready and bvalid are constant 0.
REQ-016 SHALL keep a request that arrives during another grant pending (valid held by the master per AXI).
- The request is arbitrated in the next IDLE cycle.
REQ-017 SHALL drive all axi_out outputs to 0 when not granted (no X propagation).
REQ-018 SHALL drop the in-flight transaction on reset mid-transaction.
- FSM returns to IDLE and all valid/ready outputs go to 0 in the cycle after reset asserts.

Reset
REQ-019 SHALL set, on reset: state=IDLE, last_grant=LSU, all outputs on all three ports = 0.
REQ-020 SHALL hold all outputs at 0 while reset is asserted, regardless of input activity.

Configuration
REQ-021 SHALL, with macro YSYX_24080006_ARB_RR_EN defined, arbitrate reads round-robin between IFU and LSU.
- When both read requests are present, grant the master not in last_grant.
- lsu_w keeps highest priority.
- last_grant updates on every read grant.
REQ-022 SHALL, without YSYX_24080006_ARB_RR_EN, use the fixed priority of REQ-008 with no last_grant register.

Structure
REQ-023 SHALL place the FSM state enum (arb_state_e) and master-index enum (arb_mst_e) in package ysyx_24080006_pkg.
REQ-024 SHALL place grant selection in a combinational sub-module ysyx_24080006_arb_pick.
- Inputs: request vector, last_grant.
- Output: one-hot grant.
- The sub-module is the only place the configuration macro changes behaviour.

Verification
REQ-025 SHALL cover: IFU ar addr 0xA0000000 alone → axi_out.arvalid=1 one cycle later with same addr; R data 0x12345678 rlast=1 returned to IFU; FSM back to IDLE next cycle.
REQ-026 SHALL cover: IFU and LSU arvalid same cycle, fixed mode → LSU granted; IFU arready=0 until LSU rlast handshake; IFU granted after one IDLE cycle.
REQ-027 SHALL cover: same as REQ-026 repeated 4 times with YSYX_24080006_ARB_RR_EN → grants alternate IFU, LSU, IFU, LSU (first IFU, since last_grant=LSU after reset).
REQ-028 SHALL cover: LSU awvalid+arvalid same cycle, addr 0x0200BFF8 → write granted first; read forwarded only after bvalid&&bready.
REQ-029 SHALL cover: IFU burst read arlen=3 → grant held across 4 beats; LSU arvalid asserted at beat 2 is not forwarded until after the beat-4 (rlast) handshake.
REQ-030 SHALL cover: reset asserted while in R_LSU with rvalid pending → next cycle all valid/ready=0 and state=IDLE; IFU awvalid=1 never produces axi_out.awvalid.
